pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//   Sits directly downstream of the host-core PLL wrapper; consumes its 'locked' output and drives its 'rst' input.
//   - Releases the 150 MHz core-domain reset only after lock has been stable for a programmed time.
//   - Retries the PLL on lock timeout.
//   - Re-asserts core reset on loss of lock.
//   Runs on the free-running 100 MHz reference clock, never on the PLL output.
// PARAMETERS
//   PLL_RST_CYCLES        16     cycles pll_rst is held high per PLL reset attempt (>=1)
//   LOCK_TIMEOUT_CYCLES   65536  cycles in WAIT_LOCK+STABLE before an attempt is declared failed
//   LOCK_STABLE_CYCLES    1024   consecutive synchronised locked=1 cycles required (>=1)
//   CORE_RST_HOLD_CYCLES  8      extra cycles core_rst_n stays low after lock is qualified (>=1)
//   MAX_RETRIES           3      failed attempts tolerated before entering FAIL (>=1)
//   CNT_W = $clog2(max(all cycle params)+1); RTY_W = $clog2(MAX_RETRIES+1)  (localparams)
// PORTS
//   clk            in   1      100 MHz reference clock (same net as PLL refclk)
//   rst_n          in   1      asynchronous active-low reset
//   pll_locked     in   1      PLL locked, asynchronous to clk
//   pll_rst        out  1      active-high reset to PLL
//   core_rst_n     out  1      active-low core reset; the core domain re-synchronises it
//   ready          out  1      high while in RUN
//   fail           out  1      sticky: retries exhausted
//   retry_count    out  RTY_W  failed attempts in the current bring-up
//   lock_loss_cnt  out  8      lock-loss events in RUN (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=PLL_RESET, pll_rst=1, core_rst_n=0, ready=0, fail=0, retry_count=0,
//     lock_loss_cnt=0, counters=0, sync flops=0. All outputs are registered.
//   pll_locked passes through a 2-flop synchroniser -> lk (2-cycle latency). The FSM uses only lk.
//   PLL_RESET: pll_rst=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK; clear the timeout counter.
//   WAIT_LOCK: pll_rst=0. If lk=1 -> STABLE with stable counter=0.
//     If the timeout counter reaches LOCK_TIMEOUT_CYCLES -> timeout.
//   STABLE: the timeout counter keeps running. If lk=0 -> WAIT_LOCK; the stable counter clears, the timeout counter does not.
//     After LOCK_STABLE_CYCLES consecutive lk=1 cycles -> RELEASE.
//     Timeout and lk=1-completion on the same cycle: completion wins.
//   Timeout: retry_count+1. If the new value == MAX_RETRIES -> FAIL, else -> PLL_RESET.
//   RELEASE: core_rst_n=0. After CORE_RST_HOLD_CYCLES cycles with lk=1 -> RUN.
//     lk=0 during RELEASE -> PLL_RESET (no retry increment).
//   RUN: core_rst_n=1, ready=1, retry_count cleared to 0.
//     lk=0 -> next edge: core_rst_n=0, ready=0, state=PLL_RESET.
//     core_rst_n falls exactly 3 clk edges after pll_locked falls (2 sync + 1 register).
//   FAIL: pll_rst=1, core_rst_n=0, fail=1, ready=0. Held until rst_n asserts; lk is ignored.
//   core_rst_n rises exactly 2+LOCK_STABLE_CYCLES+CORE_RST_HOLD_CYCLES edges after the first edge sampling pll_locked=1.
//     Valid when that sampling edge occurs in WAIT_LOCK and lock is not lost.
//   Glitch on pll_locked shorter than 1 cycle: may or may not be seen. Either outcome is legal; no X, no stuck state.
//   Counters saturate, never wrap; retry_count never exceeds MAX_RETRIES.
// CONFIGURATION
//   LOCK_LOSS_COUNT_EN defined:
//     - lock_loss_cnt increments by 1 on each RUN->PLL_RESET transition caused by lk=0.
//     - Saturates at 8'hFF; cleared only by rst_n.
//   LOCK_LOSS_COUNT_EN undefined:
//     - lock_loss_cnt is tied to 8'h00 and no counter logic is synthesised.
//     - All other behaviour is identical.
// TESTING  (bench params: PLL_RST=4, TIMEOUT=32, STABLE=8, HOLD=2, MAX_RETRIES=2)
//   1 Reset release, pll_locked=0: pll_rst high for 4 cycles then low. core_rst_n=0, ready=0 throughout.
//   2 pll_locked rises 10 cycles into WAIT_LOCK and stays high:
//       core_rst_n rises 12 edges after the first sampling edge; ready=1; retry_count=0.
//   3 pll_locked never rises:
//       - pll_rst re-pulses 32 cycles after the first attempt; retry_count=1.
//       - After the 2nd timeout: fail=1, pll_rst=1, retry_count=2. These persist; later lock is ignored until rst_n.
//   4 In RUN, drop pll_locked for 1 cycle-aligned sample:
//       - core_rst_n=0 on the 3rd edge; pll_rst pulses for 4 cycles.
//       - Re-lock then re-releases after 12 edges.
//       - lock_loss_cnt=1 with LOCK_LOSS_COUNT_EN, 0 without.
//   5 Toggle pll_locked 1/0 every 5 cycles in WAIT_LOCK (never 8 stable):
//       no RELEASE; timeout at 32 cycles after WAIT_LOCK entry; retry_count=1.
//   6 Assert rst_n mid-STABLE and mid-RUN: all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Bring-up sequencer for the host-core PLL. It runs on the free-running
//   reference clock and never on the PLL output. It pulses the PLL reset and
//   waits for lock. Core reset is released only after lock has been stable for
//   a programmed time. A timed-out attempt is retried until the retry budget is
//   used up, and core reset is re-asserted whenever lock is lost.
//
// Optional feature macro: LOCK_LOSS_COUNT_EN
//   When this macro is defined, lock_loss_cnt counts RUN->PLL_RESET transitions
//   caused by loss of lock. The count saturates at 8'hFF. When it is undefined,
//   lock_loss_cnt is tied to zero.
//
// Ports
//   clk            in   1      reference clock (same net as the PLL refclk)
//   rst_n          in   1      asynchronous active-low reset
//   pll_locked     in   1      PLL lock indication, asynchronous to clk
//   pll_rst        out  1      active-high reset to the PLL
//   core_rst_n     out  1      active-low core-domain reset
//   ready          out  1      high while the core is running
//   fail           out  1      sticky: retry budget exhausted
//   retry_count    out  RTY_W  failed attempts in the current bring-up
//   lock_loss_cnt  out  8      lock-loss events seen while running
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES       = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int CORE_RST_HOLD_CYCLES = 8,
    parameter int MAX_RETRIES          = 3,
    localparam int RTY_W = $clog2(MAX_RETRIES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             core_rst_n,
    output logic             ready,
    output logic             fail,
    output logic [RTY_W-1:0] retry_count,
    output logic [7:0]       lock_loss_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  max2(LOCK_STABLE_CYCLES, CORE_RST_HOLD_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal values: each phase lasts N edges, so the counter runs from 0 to N-1.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CORE_RST_HOLD_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic               sync_q1, lk;
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // phase counter: reset pulse / stable run / hold
    logic [CNT_W-1:0]   tmo_q, tmo_d;      // attempt timeout, spans WAIT_LOCK and STABLE
    logic [RTY_W-1:0]   retry_d, retry_inc;
    logic               pll_rst_d, core_rst_n_d, ready_d, fail_d;

    // Saturating increment; the FSM enters FAIL at RTY_MAX, so the cap never binds.
    assign retry_inc = (retry_count == RTY_MAX) ? retry_count : retry_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1     <= 1'b0;
            lk          <= 1'b0;
            state_q     <= S_PLL_RESET;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            core_rst_n  <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            sync_q1     <= pll_locked;
            lk          <= sync_q1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_count <= retry_d;
            pll_rst     <= pll_rst_d;
            core_rst_n  <= core_rst_n_d;
            ready       <= ready_d;
            fail        <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        retry_d = retry_count;
        case (state_q)
            S_PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (tmo_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_MAX) ? S_FAIL : S_PLL_RESET;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (lk) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end
                end
            end
            S_STABLE: begin
                // Completion is tested before timeout so that a lock that
                // qualifies on the last allowed cycle is still accepted.
                if (lk && cnt_q == STB_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RTY_MAX) ? S_FAIL : S_PLL_RESET;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (lk) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
            end
            S_RELEASE: begin
                if (!lk) begin
                    state_d = S_PLL_RESET;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_PLL_RESET;
                    cnt_d   = '0;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_PLL_RESET;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state and then registered. This
        // keeps them glitch-free and puts them on the same edge as the transition.
        pll_rst_d    = (state_d == S_PLL_RESET) || (state_d == S_FAIL);
        core_rst_n_d = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        fail_d       = (state_d == S_FAIL);
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic       lock_lost;
    logic [7:0] llc_q;

    assign lock_lost = (state_q == S_RUN) && !lk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llc_q <= 8'h00;
        end else if (lock_lost && llc_q != 8'hFF) begin
            llc_q <= llc_q + 8'h01;
        end
    end

    assign lock_loss_cnt = llc_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters:
// PLL_RST=4, TIMEOUT=32, STABLE=8, HOLD=2, MAX_RETRIES=2.
// Inputs are driven and outputs sampled on the falling clock edge. "Nk" in the
// comments is the falling edge that follows rising edge k, counted from the
// reset release.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

`ifdef LOCK_LOSS_COUNT_EN
    localparam logic [7:0] LLC_AFTER_ONE_LOSS = 8'd1;
`else
    localparam logic [7:0] LLC_AFTER_ONE_LOSS = 8'd0;
`endif

    pll_reset_sequencer #(
        .PLL_RST_CYCLES       (4),
        .LOCK_TIMEOUT_CYCLES  (32),
        .LOCK_STABLE_CYCLES   (8),
        .CORE_RST_HOLD_CYCLES (2),
        .MAX_RETRIES          (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .core_rst_n    (core_rst_n),
        .ready         (ready),
        .fail          (fail),
        .retry_count   (retry_count),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string ctx);
        check({ctx, "_pll_rst"},       32'(pll_rst),       32'd1);
        check({ctx, "_core_rst_n"},    32'(core_rst_n),    32'd0);
        check({ctx, "_ready"},         32'(ready),         32'd0);
        check({ctx, "_fail"},          32'(fail),          32'd0);
        check({ctx, "_retry_count"},   32'(retry_count),   32'd0);
        check({ctx, "_lock_loss_cnt"}, 32'(lock_loss_cnt), 32'd0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expects rst_n already low. Releases it on a falling edge, which becomes N0.
    task automatic release_reset();
        pll_locked = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit bad;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        step(3);
        check_reset_values("por");
        rst_n = 1'b1;                                // N0

        // Reset pulse: pll_rst high through E3 and low from E4.
        step(3);                                     // N3
        check("t1_pll_rst_n3", 32'(pll_rst), 32'd1);
        check("t1_core_n3",    32'(core_rst_n), 32'd0);
        step(1);                                     // N4, WAIT_LOCK entered at E4
        check("t1_pll_rst_n4", 32'(pll_rst), 32'd0);
        check("t1_ready_n4",   32'(ready), 32'd0);

        // Lock 10 cycles into WAIT_LOCK. E15 is the first sampling edge, so the
        // release lands on E15+12 = E27.
        step(10);                                    // N14
        pll_locked = 1'b1;
        step(12);                                    // N26
        check("t2_core_n26",  32'(core_rst_n), 32'd0);
        check("t2_ready_n26", 32'(ready), 32'd0);
        step(1);                                     // N27
        check("t2_core_n27",  32'(core_rst_n), 32'd1);
        check("t2_ready_n27", 32'(ready), 32'd1);
        check("t2_retry",     32'(retry_count), 32'd0);
        check("t2_pll_rst",   32'(pll_rst), 32'd0);

        // One-cycle lock drop: pll_locked is low from N29 to N30. The FSM sees
        // lk=0 at E32. pll_rst is then high over E32..E35, WAIT_LOCK is entered
        // at E36, lk=1 is seen at E37, and 8 stable cycles plus 2 hold cycles
        // give the release at E47.
        step(2);                                     // N29
        pll_locked = 1'b0;
        step(1);                                     // N30
        pll_locked = 1'b1;
        check("t4_core_n30", 32'(core_rst_n), 32'd1);
        step(1);                                     // N31
        check("t4_core_n31", 32'(core_rst_n), 32'd1);
        step(1);                                     // N32
        check("t4_core_n32",    32'(core_rst_n), 32'd0);
        check("t4_ready_n32",   32'(ready), 32'd0);
        check("t4_pll_rst_n32", 32'(pll_rst), 32'd1);
        check("t4_llc_n32",     32'(lock_loss_cnt), 32'(LLC_AFTER_ONE_LOSS));
        step(3);                                     // N35
        check("t4_pll_rst_n35", 32'(pll_rst), 32'd1);
        step(1);                                     // N36
        check("t4_pll_rst_n36", 32'(pll_rst), 32'd0);
        step(10);                                    // N46
        check("t4_core_n46", 32'(core_rst_n), 32'd0);
        step(1);                                     // N47
        check("t4_core_n47",  32'(core_rst_n), 32'd1);
        check("t4_ready_n47", 32'(ready), 32'd1);
        check("t4_llc_n47",   32'(lock_loss_cnt), 32'(LLC_AFTER_ONE_LOSS));

        // Asynchronous reset while running.
        step(3);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_run_async");

        // No lock at all: timeouts at E36 and E72. The second one enters FAIL.
        release_reset();                             // N0
        step(35);                                    // N35
        check("t3_pll_rst_n35", 32'(pll_rst), 32'd0);
        check("t3_retry_n35",   32'(retry_count), 32'd0);
        step(1);                                     // N36
        check("t3_pll_rst_n36", 32'(pll_rst), 32'd1);
        check("t3_retry_n36",   32'(retry_count), 32'd1);
        check("t3_fail_n36",    32'(fail), 32'd0);
        step(4);                                     // N40
        check("t3_pll_rst_n40", 32'(pll_rst), 32'd0);
        step(31);                                    // N71
        check("t3_pll_rst_n71", 32'(pll_rst), 32'd0);
        check("t3_fail_n71",    32'(fail), 32'd0);
        step(1);                                     // N72
        check("t3_fail_n72",    32'(fail), 32'd1);
        check("t3_pll_rst_n72", 32'(pll_rst), 32'd1);
        check("t3_retry_n72",   32'(retry_count), 32'd2);
        check("t3_core_n72",    32'(core_rst_n), 32'd0);
        pll_locked = 1'b1;
        step(40);
        check("t3_fail_held",    32'(fail), 32'd1);
        check("t3_pll_rst_held", 32'(pll_rst), 32'd1);
        check("t3_core_held",    32'(core_rst_n), 32'd0);
        check("t3_ready_held",   32'(ready), 32'd0);
        check("t3_retry_held",   32'(retry_count), 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t3_fail_async");

        // pll_locked toggles every 5 cycles from N4, so lock is never stable for
        // 8 cycles. The timeout fires at E36, 32 edges after WAIT_LOCK entry at E4.
        release_reset();                             // N0
        step(4);                                     // N4
        check("t5_pll_rst_n4", 32'(pll_rst), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pll_locked = (((i / 5) % 2) == 0);
            step(1);                                 // N(5+i)
            if (core_rst_n !== 1'b0 || ready !== 1'b0) bad = 1'b1;
            if (i < 31 && pll_rst !== 1'b0) bad = 1'b1;
        end                                          // now N36
        check("t5_no_release", 32'(bad), 32'd0);
        check("t5_pll_rst_n36", 32'(pll_rst), 32'd1);
        check("t5_retry_n36",   32'(retry_count), 32'd1);
        check("t5_fail_n36",    32'(fail), 32'd0);

        // pll_locked is still high. WAIT_LOCK is entered at E40 and STABLE at E41.
        // At N44 the FSM is in STABLE with retry_count still 1.
        step(8);                                     // N44
        check("t6_stable_pll_rst", 32'(pll_rst), 32'd0);
        check("t6_stable_retry",   32'(retry_count), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_stable_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
